// File: rtl/gcd_pkg.sv
// Shared types for the GCD core and its job driver.
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_IDLE,
        GCD_RUN,
        GCD_DONE
    } gcd_state_t;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_CHECK,
        DRV_ISSUE,
        DRV_WAIT,
        DRV_RESP
    } drv_state_t;

    localparam int GCD_TIMEOUT = 4096;

endpackage

// File: rtl/gcd.sv
// Subtractive GCD core: load operands with ld_i while ready_o, result valid in DONE until the next load.
module gcd
    import gcd_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            ld_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    gcd_state_t      state_q, state_d;
    logic [XLEN-1:0] a_q, b_q;
    logic            finished;

    assign finished = (a_q == b_q) || (a_q == '0) || (b_q == '0);

    always_comb begin
        state_d  = state_q;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        result_o = a_q;
        case (state_q)
            GCD_IDLE: begin
                ready_o = 1'b1;
                if (ld_i) state_d = GCD_RUN;
            end
            GCD_RUN: begin
                if (finished) state_d = GCD_DONE;
            end
            GCD_DONE: begin
                ready_o = 1'b1;
                valid_o = 1'b1;
                if (ld_i) state_d = GCD_RUN;
            end
            default: state_d = GCD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= GCD_IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (ld_i && ready_o) begin
                a_q <= a_i;
                b_q <= b_i;
            end else if (state_q == GCD_RUN) begin
                // a zero operand folds the other one into the result register
                if ((a_q == '0) || (b_q == '0)) a_q <= a_q | b_q;
                else if (a_q > b_q)             a_q <= a_q - b_q;
                else if (b_q > a_q)             b_q <= b_q - a_q;
            end
        end
    end

endmodule

// File: rtl/gcd_driver.sv
// Job driver for the GCD core: request/response handshakes, zero-operand bypass, timeout and statistics.
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CW      = 16,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_gcd_o,
    output logic            resp_err_o,
    output logic [CW-1:0]   resp_cycles_o,
    output logic            gcd_ld_o,
    output logic [XLEN-1:0] gcd_a_o,
    output logic [XLEN-1:0] gcd_b_o,
    input  logic            gcd_ready_i,
    input  logic            gcd_valid_i,
    input  logic [XLEN-1:0] gcd_result_i,
    output logic [15:0]     jobs_done_o,
    output logic [31:0]     busy_cycles_o
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    drv_state_t    state_q, state_d;
    logic [CW-1:0] wait_cnt_q;
    logic          has_zero;
    logic          valid_qual;
    logic          timed_out;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= TIMEOUT_C) ? TIMEOUT_C : c + 1'b1;
    endfunction

    assign has_zero   = (gcd_a_o == '0) || (gcd_b_o == '0);
    // the first WAIT cycle can still see the done flag of the previous job
    assign valid_qual = gcd_valid_i && (wait_cnt_q != '0);
    assign timed_out  = (wait_cnt_q == TIMEOUT_C);

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        gcd_ld_o     = 1'b0;
        resp_valid_o = 1'b0;
        case (state_q)
            DRV_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = DRV_CHECK;
            end
            DRV_CHECK: state_d = has_zero ? DRV_RESP : DRV_ISSUE;
            DRV_ISSUE: begin
                if (gcd_ready_i) begin
                    gcd_ld_o = 1'b1;
                    state_d  = DRV_WAIT;
                end
            end
            DRV_WAIT: begin
                if (valid_qual || timed_out) state_d = DRV_RESP;
            end
            DRV_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = DRV_IDLE;
            end
            default: state_d = DRV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= DRV_IDLE;
            wait_cnt_q    <= '0;
            gcd_a_o       <= '0;
            gcd_b_o       <= '0;
            resp_gcd_o    <= '0;
            resp_err_o    <= 1'b0;
            resp_cycles_o <= '0;
            jobs_done_o   <= '0;
            busy_cycles_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != DRV_IDLE) busy_cycles_o <= busy_cycles_o + 32'd1;
            case (state_q)
                DRV_IDLE: begin
                    if (req_valid_i) begin
                        gcd_a_o <= req_a_i;
                        gcd_b_o <= req_b_i;
                    end
                end
                DRV_CHECK: begin
                    if (has_zero) begin
                        resp_gcd_o    <= gcd_a_o | gcd_b_o;
                        resp_err_o    <= 1'b0;
                        resp_cycles_o <= '0;
                    end
                end
                DRV_ISSUE: wait_cnt_q <= '0;
                DRV_WAIT: begin
                    // a qualified valid takes priority over a coincident timeout
                    if (valid_qual) begin
                        resp_gcd_o    <= gcd_result_i;
                        resp_err_o    <= 1'b0;
                        resp_cycles_o <= wait_cnt_q;
                    end else if (timed_out) begin
                        resp_gcd_o    <= '0;
                        resp_err_o    <= 1'b1;
                        resp_cycles_o <= TIMEOUT_C;
                    end
                    wait_cnt_q <= sat_inc(wait_cnt_q);
                end
                DRV_RESP: begin
                    if (resp_ready_i) jobs_done_o <= jobs_done_o + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_driver.sv
// Scoreboard bench for gcd_driver wired to the gcd core, with a stub path for timeout and stale-valid cases.
module tb_gcd_driver;
    import gcd_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 16;
    localparam int TMO  = GCD_TIMEOUT;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid, req_ready;
    logic [XLEN-1:0] req_a, req_b;
    logic            resp_valid, resp_ready;
    logic [XLEN-1:0] resp_gcd;
    logic            resp_err;
    logic [CW-1:0]   resp_cycles;
    logic            gcd_ld;
    logic [XLEN-1:0] gcd_a, gcd_b;
    logic            core_ready, core_valid;
    logic [XLEN-1:0] core_result;
    logic            drv_ready, drv_valid;
    logic [XLEN-1:0] drv_result;
    logic [15:0]     jobs_done;
    logic [31:0]     busy_cycles;

    logic            stub_en, stub_valid;
    logic [XLEN-1:0] stub_result;
    int              rdy_mode;

    always #5 clk = ~clk;

    assign drv_ready  = stub_en ? 1'b1        : core_ready;
    assign drv_valid  = stub_en ? stub_valid  : core_valid;
    assign drv_result = stub_en ? stub_result : core_result;

    gcd_driver #(.XLEN(XLEN), .CW(CW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_gcd_o(resp_gcd), .resp_err_o(resp_err), .resp_cycles_o(resp_cycles),
        .gcd_ld_o(gcd_ld), .gcd_a_o(gcd_a), .gcd_b_o(gcd_b),
        .gcd_ready_i(drv_ready), .gcd_valid_i(drv_valid), .gcd_result_i(drv_result),
        .jobs_done_o(jobs_done), .busy_cycles_o(busy_cycles)
    );

    gcd #(.XLEN(XLEN)) core (
        .clk_i(clk), .resetn_i(resetn),
        .ld_i(gcd_ld), .a_i(gcd_a), .b_i(gcd_b),
        .ready_o(core_ready), .valid_o(core_valid), .result_o(core_result)
    );

    // response-side backpressure: 0 always ready, 1 random, 2 held low
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       resp_ready = 1'($urandom_range(0, 1));
            2:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] g;
        logic            err;
        int              cyc;
        bit              cyc_exact;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec, n_fail, n_ld, n_resp;
    logic [15:0] jobs_model;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_gcd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic push_exp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] g, input logic err, input int cyc, input bit exact);
        exp_t e;
        e.a = a; e.b = b; e.g = g; e.err = err; e.cyc = cyc; e.cyc_exact = exact;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (gcd_ld) n_ld++;
            if (resetn && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_gcd", resp_gcd, e.g);
                    check("resp_err", resp_err, e.err);
                    if (e.cyc_exact) check("resp_cycles", resp_cycles, e.cyc);
                    else             check("resp_cycles_ge1", resp_cycles >= 1, 1);
                    check("op_a_held", gcd_a, e.a);
                    check("op_b_held", gcd_b, e.b);
                    check("jobs_done", jobs_done, jobs_model);
                    check("req_ready_in_resp", req_ready, 0);
                end
                jobs_model++;
                n_resp++;
            end
        end
    endtask

    task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_a = a; req_b = b;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int target);
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (n_resp >= target) begin ok = 1; break; end
        end
        if (!ok) check("resp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_ld();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gcd_ld) begin ok = 1; break; end
        end
        if (!ok) check("ld_timeout", 0, 1);
    endtask

    task automatic job(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int t = n_resp + 1;
        bit zero = (a == 0) || (b == 0);
        push_exp(a, b, ref_gcd(a, b), 1'b0, 0, zero);
        send(a, b);
        wait_resp(t);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gcd_ld"}, gcd_ld, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_resp_gcd"}, resp_gcd, 0);
        check({tag, "_resp_cycles"}, resp_cycles, 0);
        check({tag, "_gcd_a"}, gcd_a, 0);
        check({tag, "_gcd_b"}, gcd_b, 0);
        check({tag, "_jobs_done"}, jobs_done, 0);
        check({tag, "_busy_cycles"}, busy_cycles, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        int ld0, b0, t;
        logic [XLEN-1:0] ra, rb;
        n_vec = 0; n_fail = 0; n_ld = 0; n_resp = 0; jobs_model = '0;
        req_valid = 1'b0; req_a = '0; req_b = '0;
        stub_en = 1'b0; stub_valid = 1'b0; stub_result = '0;
        rdy_mode = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        ld0 = n_ld;
        job(48, 18);
        check("ld_pulses_48_18", n_ld - ld0, 1);
        check("jobs_after_first", jobs_done, 1);

        ld0 = n_ld; b0 = busy_cycles;
        job(0, 35);
        check("ld_pulses_0_35", n_ld - ld0, 0);
        check("busy_delta_zero_op", busy_cycles - b0, 2);
        job(0, 0);
        job(35, 0);

        // backpressure: response must hold while resp_ready stays low
        rdy_mode = 2;
        t = n_resp + 1;
        push_exp(17, 5, 1, 1'b0, 0, 0);
        send(17, 5);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_gcd", resp_gcd, 1);
            check("bp_req_ready", req_ready, 0);
        end
        rdy_mode = 0;
        wait_resp(t);

        // stale done on the first WAIT cycle must be ignored
        stub_en = 1'b1; stub_valid = 1'b1; stub_result = 32'hBAD;
        t = n_resp + 1;
        push_exp(42, 63, 21, 1'b0, 3, 1);
        send(42, 63);
        wait_ld();
        @(posedge clk); #1;
        @(posedge clk); #1 stub_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 stub_valid = 1'b1; stub_result = 21;
        wait_resp(t);
        stub_valid = 1'b0;

        // core never answers: timeout response
        ld0 = n_ld; b0 = busy_cycles;
        t = n_resp + 1;
        push_exp(9, 6, 0, 1'b1, TMO, 1);
        send(9, 6);
        wait_resp(t);
        check("ld_pulses_timeout", n_ld - ld0, 1);
        check("busy_delta_timeout", busy_cycles - b0, TMO + 4);
        stub_en = 1'b0;

        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1500);
            rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1500);
            job(ra, rb);
        end
        rdy_mode = 0;

        // reset while the driver is waiting on the core
        stub_en = 1'b1; stub_valid = 1'b0;
        send(30, 20);
        wait_ld();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check_reset_values("midjob");
        exp_q.delete();
        jobs_model = '0;
        stub_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("ready_after_midjob_reset", req_ready, 1);
        job(12, 8);
        check("jobs_after_midjob_reset", jobs_done, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_driver.md
GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter CW, default 16, cycle-count width.
REQ-003 Parameter TIMEOUT, default 4096, max wait cycles before error; SHALL be < 2**CW.
REQ-004 clk_i  in  1  single clock, all logic rising-edge.
REQ-005 resetn_i  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  job request handshake.
REQ-007 req_a_i, req_b_i  in  XLEN  job operands.
REQ-008 resp_valid_o / resp_ready_i  out/in  1/1  job response handshake.
REQ-009 resp_gcd_o  out  XLEN  result; resp_err_o  out  1  timeout flag; resp_cycles_o  out  CW  core latency of this job.
REQ-010 gcd_ld_o  out  1  load strobe to core; gcd_a_o, gcd_b_o  out  XLEN  core operands.
REQ-011 gcd_ready_i, gcd_valid_i  in  1  core idle / core done; gcd_result_i  in  XLEN  core result.
REQ-012 jobs_done_o  out  16  completed-job count; busy_cycles_o  out  32  cycles spent outside IDLE.

Function
REQ-013 States IDLE, CHECK, ISSUE, WAIT, RESP; one state register.
REQ-014 req_ready_o SHALL be 1 only in IDLE; req_valid_i&req_ready_o registers req_a_i/req_b_i into gcd_a_o/gcd_b_o and moves to CHECK.
REQ-015 CHECK, either operand zero: resp_gcd_o = nonzero operand (0 if both zero), resp_err_o=0, resp_cycles_o=0, go to RESP; no gcd_ld_o pulse.
REQ-016 CHECK, both nonzero: go to ISSUE.
REQ-017 ISSUE: when gcd_ready_i=1, gcd_ld_o SHALL be 1 for exactly that one cycle and state moves to WAIT; otherwise stay in ISSUE with gcd_ld_o=0.
REQ-018 WAIT: wait counter clears on entry and increments each WAIT cycle, saturating at TIMEOUT.
REQ-019 gcd_valid_i SHALL be ignored on the first WAIT cycle (counter=0), masking stale done from the prior job.
REQ-020 WAIT, gcd_valid_i=1 with counter>=1: capture gcd_result_i into resp_gcd_o, resp_cycles_o=counter, resp_err_o=0, go to RESP.
REQ-021 WAIT, counter reaches TIMEOUT without qualified valid: resp_gcd_o=0, resp_err_o=1, resp_cycles_o=TIMEOUT, go to RESP.
REQ-022 Valid and timeout in the same cycle: valid wins, err=0.
REQ-023 RESP: resp_valid_o=1 and resp_* stable until resp_ready_i=1; on handshake go to IDLE and increment jobs_done_o.
REQ-024 Back-to-back: a new request SHALL NOT be accepted in the RESP-handshake cycle; earliest acceptance is the following cycle.
REQ-025 jobs_done_o and busy_cycles_o SHALL wrap modulo 2**16 / 2**32.
REQ-026 gcd_a_o/gcd_b_o SHALL hold operands from acceptance until return to IDLE.

Reset
REQ-027 Reset SHALL force IDLE; req_ready_o=1 in the first cycle after deassertion.
REQ-028 Reset values: gcd_ld_o=0, resp_valid_o=0, resp_err_o=0, resp_gcd_o=0, resp_cycles_o=0, gcd_a_o=0, gcd_b_o=0, counters=0.
REQ-029 Reset mid-job SHALL abandon the job with no response; the core is reset from the same resetn_i.

Structure
REQ-030 The state enum drv_state_t SHALL live in gcd_pkg next to the core's state type; TIMEOUT default as a gcd_pkg localparam.
REQ-031 Single module, no sub-modules; the testbench SHALL instantiate gcd with gcd_driver wired ld/a/b/ready/valid/result.

Verification
REQ-032 req (48,18) -> one gcd_ld_o pulse, resp_gcd_o=6, err=0, resp_cycles_o>=1, jobs_done_o=1.
REQ-033 req (0,35) -> no gcd_ld_o, resp_gcd_o=35, resp_cycles_o=0; req (0,0) -> resp_gcd_o=0.
REQ-034 Core stub with gcd_valid_i tied 0 -> resp_err_o=1, resp_gcd_o=0, resp_cycles_o=4096.
REQ-035 resp_ready_i held 0 for 5 cycles on (17,5) -> resp_valid_o and resp_gcd_o=1 stable, req_ready_o=0 throughout.
REQ-036 gcd_valid_i stuck 1 from prior job on the first WAIT cycle -> ignored; result taken from a later valid.
REQ-037 resetn_i asserted during WAIT -> all REQ-028 values immediately; next job (12,8) returns 4.
